mem_arbiter: RTL

- Two-requester arbiter and sequencer for the 16x1k distributed memory (mem16x1k_dist_sch: Write, Address[9:0], DataIn[15:0], DataOut[15:0]).
- The memory has a synchronous write on the CLK rising edge and an asynchronous read.
- Shares the memory between port A (instruction fetch) and port B (data load/store) using a req/ack handshake and round-robin arbitration.
- Drives all memory inputs from registers and captures read data per port.

---
 rtl/mem_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a 16x1k distributed memory
// with synchronous write and asynchronous read. Port A is the instruction
// fetch side and port B the data load/store side. Each granted access takes
// IDLE -> ACCESS -> DONE. All memory inputs are driven from registers.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  A_Req,
    input  logic                  A_We,
    input  logic [ADDR_WIDTH-1:0] A_Addr,
    input  logic [DATA_WIDTH-1:0] A_WData,
    output logic                  A_Ack,
    output logic [DATA_WIDTH-1:0] A_RData,
    input  logic                  B_Req,
    input  logic                  B_We,
    input  logic [ADDR_WIDTH-1:0] B_Addr,
    input  logic [DATA_WIDTH-1:0] B_WData,
    output logic                  B_Ack,
    output logic [DATA_WIDTH-1:0] B_RData,
    output logic                  Mem_Write,
    output logic [ADDR_WIDTH-1:0] Mem_Address,
    output logic [DATA_WIDTH-1:0] Mem_DataIn,
    input  logic [DATA_WIDTH-1:0] Mem_DataOut,
    output logic                  Busy,
    output logic [1:0]            Grant
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t state;
    logic   prio_b;
    logic   owner_b;
    logic   pick_b;

    // Winner selection: a lone requester wins; on a tie the priority pointer decides
    always_comb begin
        pick_b = B_Req && (!A_Req || prio_b);
    end

    // Sequencer: latch the winner's command, perform the access, pulse Ack, release
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= IDLE;
            prio_b      <= 1'b0;
            owner_b     <= 1'b0;
            Mem_Write   <= 1'b0;
            Mem_Address <= '0;
            Mem_DataIn  <= '0;
            A_Ack       <= 1'b0;
            B_Ack       <= 1'b0;
            A_RData     <= '0;
            B_RData     <= '0;
            Busy        <= 1'b0;
            Grant       <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (A_Req || B_Req) begin
                        owner_b     <= pick_b;
                        Mem_Address <= pick_b ? B_Addr : A_Addr;
                        Mem_DataIn  <= pick_b ? B_WData : A_WData;
                        Mem_Write   <= pick_b ? B_We : A_We;
                        Grant       <= pick_b ? 2'b10 : 2'b01;
                        Busy        <= 1'b1;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    Mem_Write <= 1'b0;
                    if (owner_b) begin
                        B_Ack <= 1'b1;
                        if (!Mem_Write) begin
                            B_RData <= Mem_DataOut;
                        end
                    end else begin
                        A_Ack <= 1'b1;
                        if (!Mem_Write) begin
                            A_RData <= Mem_DataOut;
                        end
                    end
                    prio_b <= !owner_b;
                    state  <= DONE;
                end
                DONE: begin
                    A_Ack <= 1'b0;
                    B_Ack <= 1'b0;
                    Grant <= 2'b00;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
